// File: rtl/fir_decim.sv
// Decimating accumulator: averages N=2**DECIM_LOG2 samples per result
// and queues results in a first-word-fall-through output FIFO.
module fir_decim #(
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [15:0]            In,
  output logic signed [15:0]            out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW  = 16 + DECIM_LOG2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PHW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PHW-1:0] LAST = PHW'((1 << DECIM_LOG2) - 1);
  localparam logic [CW-1:0]  FULL = CW'(FIFO_DEPTH);

  logic signed [AW-1:0] r_acc;
  logic [PHW-1:0]       r_phase;
  logic [PW-1:0]        r_wr;
  logic [PW-1:0]        r_rd;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic signed [15:0]   r_mem [FIFO_DEPTH];

  logic signed [AW-1:0] w_sum;
  logic signed [15:0]   w_res;
  logic                 w_last;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;

  // Sum of N samples always fits in AW bits; the top 16 bits are the
  // floor-shifted mean.
  assign w_sum  = r_acc + AW'(In);
  assign w_res  = w_sum[AW-1 -: 16];
  assign w_last = in_valid & (r_phase == LAST);
  assign w_full = (r_count == FULL);
  assign w_pop  = out_valid & out_ready;
  assign w_wr   = w_last & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (in_valid) begin
      if (w_last) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_last & w_full & ~w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: out_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr] <= w_res;
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 Parameter DECIM_LOG2, default 2: decimation factor N = 2**DECIM_LOG2 samples per output.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; deassertion sampled on clk rising edge.
REQ-005 in_valid  input  1  In carries a valid sample this cycle.
REQ-006 In  input  16  signed sample from the upstream fir stage's Out port.
REQ-007 out_data  output  16  signed decimated result at FIFO head.
REQ-008 out_valid  output  1  FIFO non-empty; out_data meaningful.
REQ-009 out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 overflow  output  1  sticky: a result was dropped because the FIFO was full.

Function
REQ-012 Accumulator SHALL be signed, 16+DECIM_LOG2 bits wide; each In SHALL be sign-extended before addition; no intermediate wrap is permitted.
REQ-013 Phase counter SHALL run 0..N-1, advancing only on edges where in_valid=1; in_valid=0 SHALL hold accumulator and phase.
REQ-014 Accepted sample with phase<N-1: acc <= acc+In, phase <= phase+1.
REQ-015 Accepted sample with phase=N-1: result = (acc+In) arithmetic-shifted right by DECIM_LOG2 (floor toward -inf), truncated to 16 bits; acc <= 0; phase <= 0; push result.
REQ-016 Result SHALL always fit in 16 bits (mean of N 16-bit values); no saturation logic required.
REQ-017 FIFO SHALL be first-word-fall-through: out_valid = (count!=0); out_data = head entry when out_valid=1, else 0.
REQ-018 Latency: out_valid and out_data SHALL reflect a pushed result immediately after the rising edge that accepts the Nth sample, with no further delay cycles.
REQ-019 Pop occurs on a rising edge with out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-020 Push and pop on the same edge SHALL both take effect, count unchanged, including when count=FIFO_DEPTH; overflow is not set in that case.
REQ-021 Push with count=FIFO_DEPTH and no pop: result dropped, FIFO contents unchanged, overflow <= 1; accumulator and phase still clear.
REQ-022 overflow SHALL remain 1 until reset.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; output order SHALL equal push order across wrap.
REQ-024 Push SHALL occur only from REQ-015; no other path writes the FIFO.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force acc=0, phase=0, pointers=0, count=0, out_valid=0, out_data=0, overflow=0.
REQ-026 Reset mid-block SHALL discard partial accumulation and all FIFO contents; the first accepted sample after release begins a fresh block at phase 0.
REQ-027 While rst_n=0, in_valid and out_ready SHALL be ignored.

Verification
REQ-028 Reset; in_valid=1, In=1,4,16,4 on consecutive cycles; out_ready=0 -> after 4th edge out_valid=1, out_data=6 (25>>>2), count=1.
REQ-029 In=-1,-5,-21,-25 -> out_data=-13 (floor of -52/4); then four samples of 32767 -> 32767; four samples of -32768 -> -32768; no wrap.
REQ-030 Samples 8,8,8,8 with in_valid low for 3 cycles between each -> phase holds during gaps; exactly one result, value 8, after 4th valid edge.
REQ-031 out_ready=0; 20 valid samples of value 4 -> count reaches 4, 5th result dropped, overflow=1; then out_ready=1 -> four results of 4 on successive cycles, out_valid=0, overflow still 1.
REQ-032 FIFO full (count=4), out_ready=1 held on the edge accepting a 4th sample -> count stays 4, overflow stays 0, pop and push order preserved across pointer wrap.
REQ-033 After 2 accepted samples of value 100 and one stored result, assert rst_n=0 mid-cycle -> out_valid=0, count=0 with no clock edge; after release, samples 2,2,2,2 -> out_data=2.
